// File: rtl/vid_in_axi4s_pkg.sv
// Shared definitions for the video-in to AXI4-Stream packer: FSM states,
// pixel/beat width helpers and the layout of a FIFO entry above the pixel data.
package vid_in_axi4s_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_VBLANK = 2'd0,
        ST_SYNCED      = 2'd1,
        ST_DROP_LINE   = 2'd2
    } state_t;

    // Sideband bits sit directly above the TW data bits of each FIFO entry.
    localparam int ENT_TUSER_OFS  = 0;
    localparam int ENT_TLAST_OFS  = 1;
    localparam int ENT_FID_OFS    = 2;
    localparam int ENT_SIDEBAND_W = 3;

    function automatic int pw_f(input int cpp, input int cw);
        return cpp * cw;
    endfunction

    function automatic int tw_f(input int pf, input int cpp, input int cw);
        return pf * pw_f(cpp, cw);
    endfunction

endpackage

// File: rtl/vid_in_axi4s_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout is forced to zero while empty
// so the stream outputs stay quiet when nothing is buffered.
module vid_in_axi4s_sync_fifo #(
    parameter int C_DATA_WIDTH = 51,
    parameter int C_ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [C_DATA_WIDTH-1:0] din,
    output logic                    full,
    input  logic                    rd_en,
    output logic [C_DATA_WIDTH-1:0] dout,
    output logic                    empty
);

    localparam int DEPTH = 1 << C_ADDR_WIDTH;

    logic [C_DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [C_ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [C_ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                    wr_fire;
    logic                    rd_fire;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[C_ADDR_WIDTH] != rd_ptr_q[C_ADDR_WIDTH]) &&
                   (wr_ptr_q[C_ADDR_WIDTH-1:0] == rd_ptr_q[C_ADDR_WIDTH-1:0]);

    always_comb begin
        wr_fire  = wr_en && !full;
        rd_fire  = rd_en && !empty;
        wr_ptr_d = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[C_ADDR_WIDTH-1:0]] <= din;
        end
    end

    assign dout = empty ? '0 : mem_q[rd_ptr_q[C_ADDR_WIDTH-1:0]];

endmodule

// File: rtl/vid_in_axi4s_packer.sv
// Native video input to AXI4-Stream: locks to vblank, packs C_PACK_FACTOR pixels
// per beat, marks start-of-frame / end-of-line and buffers beats in a FWFT FIFO.
module vid_in_axi4s_packer
    import vid_in_axi4s_pkg::*;
#(
    parameter int C_COMPONENTS_PER_PIXEL = 3,
    parameter int C_COMPONENT_WIDTH      = 8,
    parameter int C_PACK_FACTOR          = 2,
    parameter int C_ADDR_WIDTH           = 5,
    parameter int C_DROP_ON_OVERFLOW     = 1,
    localparam int PW = pw_f(C_COMPONENTS_PER_PIXEL, C_COMPONENT_WIDTH),
    localparam int TW = tw_f(C_PACK_FACTOR, C_COMPONENTS_PER_PIXEL, C_COMPONENT_WIDTH)
) (
    input  logic          vid_io_in_clk,
    input  logic          vid_io_in_reset,
    input  logic          vid_io_in_ce,
    input  logic          vid_active_video,
    input  logic          vid_vblank,
    input  logic          vid_field_id,
    input  logic [PW-1:0] vid_data,
    input  logic          axis_enable,
    output logic [TW-1:0] m_axis_video_tdata,
    output logic          m_axis_video_tvalid,
    input  logic          m_axis_video_tready,
    output logic          m_axis_video_tuser,
    output logic          m_axis_video_tlast,
    output logic          fid,
    output logic          overflow,
    output logic [15:0]   lines_dropped,
    output logic          synced
);

    localparam int LW = (C_PACK_FACTOR > 1) ? $clog2(C_PACK_FACTOR) : 1;
    localparam int EW = TW + ENT_SIDEBAND_W;
    localparam logic [LW-1:0] LANE_LAST = LW'(C_PACK_FACTOR - 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   acc_q, acc_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic            beat_full_q, beat_full_d;
    logic            fid_q, fid_d;
    logic            sof_q, sof_d;
    logic            line_hit_q, line_hit_d;
    logic [15:0]     lines_dropped_q, lines_dropped_d;
    logic            overflow_q, overflow_d;

    logic            push;
    logic            push_last;
    logic            reject;
    logic [EW-1:0]   push_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   fifo_dout;

    always_ff @(posedge vid_io_in_clk or posedge vid_io_in_reset) begin
        if (vid_io_in_reset) begin
            state_q         <= ST_WAIT_VBLANK;
            acc_q           <= '0;
            lane_q          <= '0;
            beat_full_q     <= 1'b0;
            fid_q           <= 1'b0;
            sof_q           <= 1'b0;
            line_hit_q      <= 1'b0;
            lines_dropped_q <= '0;
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_q           <= acc_d;
            lane_q          <= lane_d;
            beat_full_q     <= beat_full_d;
            fid_q           <= fid_d;
            sof_q           <= sof_d;
            line_hit_q      <= line_hit_d;
            lines_dropped_q <= lines_dropped_d;
            overflow_q      <= overflow_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        lane_d          = lane_q;
        beat_full_d     = beat_full_q;
        fid_d           = fid_q;
        sof_d           = sof_q;
        line_hit_d      = line_hit_q;
        lines_dropped_d = lines_dropped_q;
        overflow_d      = 1'b0;
        push            = 1'b0;
        push_last       = 1'b0;
        reject          = 1'b0;

        if (!axis_enable) begin
            state_d     = ST_WAIT_VBLANK;
            acc_d       = '0;
            lane_d      = '0;
            beat_full_d = 1'b0;
            sof_d       = 1'b0;
            line_hit_d  = 1'b0;
        end else if (vid_io_in_ce) begin
            case (state_q)
                ST_WAIT_VBLANK: begin
                    if (vid_vblank) begin
                        state_d     = ST_SYNCED;
                        sof_d       = 1'b1;
                        acc_d       = '0;
                        lane_d      = '0;
                        beat_full_d = 1'b0;
                    end
                end

                ST_SYNCED: begin
                    // A completed beat waits one ce cycle so tlast can see whether the line ended.
                    if (beat_full_q) begin
                        push      = 1'b1;
                        push_last = !vid_active_video;
                    end else if (!vid_active_video && (lane_q != '0)) begin
                        push      = 1'b1;
                        push_last = 1'b1;
                    end
                    reject = push && fifo_full;

                    if (vid_active_video) begin
                        if (lane_q == '0) begin
                            acc_d = '0;
                            fid_d = vid_field_id;
                        end
                        acc_d[int'(lane_q)*PW +: PW] = vid_data;
                        beat_full_d = (lane_q == LANE_LAST);
                        lane_d      = (lane_q == LANE_LAST) ? '0 : lane_q + LW'(1);
                    end else begin
                        acc_d       = '0;
                        lane_d      = '0;
                        beat_full_d = 1'b0;
                        line_hit_d  = 1'b0;
                    end

                    if (push && !fifo_full) begin
                        sof_d = 1'b0;
                    end

                    if (reject) begin
                        overflow_d = 1'b1;
                        if (C_DROP_ON_OVERFLOW != 0) begin
                            lines_dropped_d = (lines_dropped_q == 16'hFFFF) ?
                                              lines_dropped_q : lines_dropped_q + 16'd1;
                            if (vid_active_video) begin
                                state_d     = ST_DROP_LINE;
                                acc_d       = '0;
                                lane_d      = '0;
                                beat_full_d = 1'b0;
                            end
                        end else begin
                            if (!line_hit_q) begin
                                lines_dropped_d = (lines_dropped_q == 16'hFFFF) ?
                                                  lines_dropped_q : lines_dropped_q + 16'd1;
                            end
                            line_hit_d = vid_active_video;
                        end
                    end

                    if (vid_vblank) begin
                        sof_d = 1'b1;
                    end
                end

                ST_DROP_LINE: begin
                    if (!vid_active_video) begin
                        state_d     = ST_SYNCED;
                        acc_d       = '0;
                        lane_d      = '0;
                        beat_full_d = 1'b0;
                    end
                    if (vid_vblank) begin
                        sof_d = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_WAIT_VBLANK;
                end
            endcase
        end
    end

    always_comb begin
        push_entry                     = '0;
        push_entry[TW-1:0]             = acc_q;
        push_entry[TW + ENT_TUSER_OFS] = sof_q;
        push_entry[TW + ENT_TLAST_OFS] = push_last;
        push_entry[TW + ENT_FID_OFS]   = fid_q;
    end

    vid_in_axi4s_sync_fifo #(
        .C_DATA_WIDTH (EW),
        .C_ADDR_WIDTH (C_ADDR_WIDTH)
    ) u_fifo (
        .clk   (vid_io_in_clk),
        .rst   (vid_io_in_reset),
        .wr_en (push),
        .din   (push_entry),
        .full  (fifo_full),
        .rd_en (m_axis_video_tready),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign m_axis_video_tvalid = !fifo_empty;
    assign m_axis_video_tdata  = fifo_dout[TW-1:0];
    assign m_axis_video_tuser  = fifo_dout[TW + ENT_TUSER_OFS];
    assign m_axis_video_tlast  = fifo_dout[TW + ENT_TLAST_OFS];
    assign fid                 = fifo_dout[TW + ENT_FID_OFS];
    assign overflow            = overflow_q;
    assign lines_dropped       = lines_dropped_q;
    assign synced              = (state_q == ST_SYNCED) || (state_q == ST_DROP_LINE);

endmodule

// File: tb/tb_vid_in_axi4s_packer.sv
// Directed bench for vid_in_axi4s_packer (3x8-bit pixels, 2 per beat, depth 32)
// with a queue-based beat model and a per-cycle output compare process.
module tb_vid_in_axi4s_packer;

    localparam int PF = 2;
    localparam int PW = 24;
    localparam int TW = 48;

    typedef struct {
        logic [TW-1:0] data;
        logic          user;
        logic          last;
        logic          fid;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          active;
    logic          vblank;
    logic          field;
    logic [PW-1:0] vdata;
    logic          axis_en;
    logic [TW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tuser;
    logic          tlast;
    logic          fid_o;
    logic          overflow;
    logic [15:0]   lines_dropped;
    logic          synced;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            ovf_cnt  = 0;

    beat_t         exp_q[$];
    beat_t         cmp_e;
    logic [PW-1:0] line_pix [0:127];
    int            samp_cyc [0:127];
    logic [TW-1:0] got_data [0:255];
    logic          got_last [0:255];
    logic          got_user [0:255];
    int            got_cyc  [0:255];
    int            n_got    = 0;

    vid_in_axi4s_packer dut (
        .vid_io_in_clk       (clk),
        .vid_io_in_reset     (rst),
        .vid_io_in_ce        (ce),
        .vid_active_video    (active),
        .vid_vblank          (vblank),
        .vid_field_id        (field),
        .vid_data            (vdata),
        .axis_enable         (axis_en),
        .m_axis_video_tdata  (tdata),
        .m_axis_video_tvalid (tvalid),
        .m_axis_video_tready (tready),
        .m_axis_video_tuser  (tuser),
        .m_axis_video_tlast  (tlast),
        .fid                 (fid_o),
        .overflow            (overflow),
        .lines_dropped       (lines_dropped),
        .synced              (synced)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Output compare: every accepted beat is matched against the model queue.
    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_cnt++;
        if (!rst && tvalid && tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat_tvalid", 64'(tvalid), 64'd0);
            end else begin
                cmp_e = exp_q.pop_front();
                check("beat_tdata", 64'(tdata), 64'(cmp_e.data));
                check("beat_tuser", 64'(tuser), 64'(cmp_e.user));
                check("beat_tlast", 64'(tlast), 64'(cmp_e.last));
                check("beat_fid",   64'(fid_o), 64'(cmp_e.fid));
                $display("beat %0d: tdata=%012h tuser=%0b tlast=%0b fid=%0b", n_got, tdata, tuser, tlast, fid_o);
            end
            if (n_got < 256) begin
                got_data[n_got] = tdata;
                got_last[n_got] = tlast;
                got_user[n_got] = tuser;
                got_cyc[n_got]  = cyc;
            end
            n_got++;
        end
    end

    // Model: a line of n pixels becomes ceil(n/PF) beats, pixel 0 in the LSBs,
    // missing lanes zero; only the first 'keep' beats survive an overflow.
    task automatic add_expected(input int n, input bit sof, input bit f, input int keep);
        int    nb;
        beat_t e;
        nb = (n + PF - 1) / PF;
        for (int b = 0; b < nb; b++) begin
            e.data = '0;
            for (int l = 0; l < PF; l++) begin
                if (b * PF + l < n) e.data[l*PW +: PW] = line_pix[b*PF + l];
            end
            e.user = sof && (b == 0);
            e.last = (b == nb - 1);
            e.fid  = f;
            if (b < keep) exp_q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic off_cycle();
        ce     = 1'b0;
        active = 1'($urandom_range(0, 1));
        vblank = 1'($urandom_range(0, 1));
        field  = 1'($urandom_range(0, 1));
        vdata  = PW'($urandom);
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            ce = 1'b1; active = 1'b0; vblank = 1'b0; vdata = '0;
            step();
        end
    endtask

    task automatic vblank_pulse(input int n);
        for (int k = 0; k < n; k++) begin
            ce = 1'b1; active = 1'b0; vblank = 1'b1; vdata = '0;
            step();
        end
        vblank = 1'b0;
    endtask

    task automatic send_line(input int n, input bit f, input bit alt);
        for (int i = 0; i < n; i++) begin
            ce = 1'b1; active = 1'b1; vblank = 1'b0; field = f; vdata = line_pix[i];
            step();
            samp_cyc[i] = cyc;
            if (alt) off_cycle();
        end
        for (int k = 0; k < 4; k++) begin
            ce = 1'b1; active = 1'b0; vblank = 1'b0; vdata = '0;
            step();
            if (alt) off_cycle();
        end
        ce = 1'b1; active = 1'b0; vblank = 1'b0;
    endtask

    task automatic load_req26();
        line_pix[0] = 24'h010203;
        line_pix[1] = 24'h040506;
        line_pix[2] = 24'h070809;
        line_pix[3] = 24'h0A0B0C;
    endtask

    initial begin : stim
        int base;
        int ovf_base;
        rst = 1'b1; ce = 1'b0; active = 1'b0; vblank = 1'b0; field = 1'b0;
        vdata = '0; axis_en = 1'b1; tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid",   64'(tvalid), 64'd0);
        check("rst_tdata",    64'(tdata), 64'd0);
        check("rst_tuser",    64'(tuser), 64'd0);
        check("rst_tlast",    64'(tlast), 64'd0);
        check("rst_fid",      64'(fid_o), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_synced",   64'(synced), 64'd0);
        check("rst_dropped",  64'(lines_dropped), 64'd0);
        rst = 1'b0;

        // Pixels before any vblank must be ignored.
        load_req26();
        send_line(4, 1'b0, 1'b0);
        check("presync_synced", 64'(synced), 64'd0);
        check("presync_tvalid", 64'(tvalid), 64'd0);

        // Four-pixel line right after vblank.
        vblank_pulse(3);
        check("vblank_synced", 64'(synced), 64'd1);
        base = n_got;
        add_expected(4, 1'b1, 1'b0, 99);
        send_line(4, 1'b0, 1'b0);
        idle(4);
        check("l4_count",   64'(n_got - base), 64'd2);
        check("l4_beat0",   64'(got_data[base]), 64'h040506010203);
        check("l4_user0",   64'(got_user[base]), 64'd1);
        check("l4_beat1",   64'(got_data[base+1]), 64'h0A0B0C070809);
        check("l4_last1",   64'(got_last[base+1]), 64'd1);
        check("l4_latency", 64'(got_cyc[base]), 64'(samp_cyc[2]));

        // Three-pixel line, field 1: zero-filled partial beat.
        line_pix[0] = 24'h0D0E0F;
        line_pix[1] = 24'h101112;
        line_pix[2] = 24'h131415;
        base = n_got;
        add_expected(3, 1'b0, 1'b1, 99);
        send_line(3, 1'b1, 1'b0);
        idle(4);
        check("l3_count", 64'(n_got - base), 64'd2);
        check("l3_beat1", 64'(got_data[base+1]), 64'h000000131415);
        check("l3_last1", 64'(got_last[base+1]), 64'd1);

        // Same four-pixel line with clock enable toggling.
        vblank_pulse(2);
        load_req26();
        base = n_got;
        add_expected(4, 1'b1, 1'b0, 99);
        send_line(4, 1'b0, 1'b1);
        idle(4);
        check("ce_count", 64'(n_got - base), 64'd2);
        check("ce_beat0", 64'(got_data[base]), 64'h040506010203);
        check("ce_beat1", 64'(got_data[base+1]), 64'h0A0B0C070809);

        // Overflow: 35 beats offered into a stalled 32-deep FIFO.
        tready = 1'b0;
        ovf_base = ovf_cnt;
        vblank_pulse(2);
        for (int i = 0; i < 70; i++) line_pix[i] = 24'h100000 + 24'(i);
        base = n_got;
        add_expected(70, 1'b1, 1'b0, 32);
        send_line(70, 1'b0, 1'b0);
        idle(2);
        check("ovf_pulses",  64'(ovf_cnt - ovf_base), 64'd1);
        check("ovf_dropped", 64'(lines_dropped), 64'd1);
        check("ovf_tvalid",  64'(tvalid), 64'd1);
        tready = 1'b1;
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
        check("ovf_drained",  64'(exp_q.size()), 64'd0);
        check("ovf_count",    64'(n_got - base), 64'd32);
        check("ovf_lastbeat", 64'(got_last[base+31]), 64'd0);
        line_pix[0] = 24'hAABBCC;
        line_pix[1] = 24'h112233;
        add_expected(2, 1'b0, 1'b0, 99);
        send_line(2, 1'b0, 1'b0);
        idle(3);

        // Reset in the middle of a line with beats buffered.
        tready = 1'b0;
        vblank_pulse(2);
        for (int i = 0; i < 6; i++) begin
            ce = 1'b1; active = 1'b1; vdata = 24'h550000 + 24'(i);
            step();
        end
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("mrst_tvalid",  64'(tvalid), 64'd0);
        check("mrst_tdata",   64'(tdata), 64'd0);
        check("mrst_synced",  64'(synced), 64'd0);
        check("mrst_dropped", 64'(lines_dropped), 64'd0);
        active = 1'b0;
        step();
        step();
        rst = 1'b0;
        tready = 1'b1;
        load_req26();
        send_line(4, 1'b0, 1'b0);
        check("postrst_synced", 64'(synced), 64'd0);
        check("postrst_tvalid", 64'(tvalid), 64'd0);

        // vblank with axis_enable low must not lock.
        axis_en = 1'b0;
        vblank_pulse(3);
        check("noen_synced", 64'(synced), 64'd0);
        send_line(4, 1'b0, 1'b0);
        check("noen_tvalid", 64'(tvalid), 64'd0);
        axis_en = 1'b1;
        vblank_pulse(2);
        check("reen_synced", 64'(synced), 64'd1);
        base = n_got;
        add_expected(4, 1'b1, 1'b0, 99);
        send_line(4, 1'b0, 1'b0);
        idle(4);
        check("reen_count", 64'(n_got - base), 64'd2);

        check("model_empty", 64'(exp_q.size()), 64'd0);
        check("total_ovf",   64'(ovf_cnt), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vid_in_axi4s_packer.md
VID_IN_AXI4S_PACKER -- requirements
Module: vid_in_axi4s_packer

Interface
REQ-001 SHALL have parameter C_COMPONENTS_PER_PIXEL, default 3, components per native pixel [1..4].
REQ-002 SHALL have parameter C_COMPONENT_WIDTH, default 8, bits per component [8,10,12,16].
REQ-003 SHALL have parameter C_PACK_FACTOR, default 2, native pixels packed per AXIS beat [1,2,4].
REQ-004 SHALL have parameter C_ADDR_WIDTH, default 5, FIFO depth = 2^C_ADDR_WIDTH entries.
REQ-005 SHALL have parameter C_DROP_ON_OVERFLOW, default 1; 1 = drop rest of line on overflow, 0 = drop single beats.
REQ-006 SHALL define PW = C_COMPONENTS_PER_PIXEL*C_COMPONENT_WIDTH and TW = C_PACK_FACTOR*PW.
REQ-007 SHALL use one clock and an asynchronous, active-high reset:
  vid_io_in_clk  in  1  sole clock, rising edge
  vid_io_in_reset  in  1  asynchronous reset, active high
  vid_io_in_ce  in  1  native clock enable; input sampled only when 1
  vid_active_video  in  1  pixel valid
  vid_vblank  in  1  vertical blank
  vid_field_id  in  1  field id
  vid_data  in  PW  native pixel
  axis_enable  in  1  timing locked; 0 forces resync
  m_axis_video_tdata  out  TW  packed pixels, pixel 0 in LSBs
  m_axis_video_tvalid  out  1  beat valid
  m_axis_video_tready  in  1  downstream ready
  m_axis_video_tuser  out  1  start of frame
  m_axis_video_tlast  out  1  end of line
  fid  out  1  field id of beat
  overflow  out  1  one-cycle pulse per rejected push
  lines_dropped  out  16  saturating count of lines truncated by overflow
  synced  out  1  1 in state SYNCED or DROP_LINE

Function
REQ-008 SHALL implement FSM WAIT_VBLANK, SYNCED, DROP_LINE; reset state WAIT_VBLANK.
REQ-009 WAIT_VBLANK -> SYNCED on ce && vid_vblank && axis_enable; no pixels accepted in WAIT_VBLANK.
REQ-010 Any state -> WAIT_VBLANK in the cycle axis_enable is sampled 0; pending partial beat discarded.
REQ-011 SHALL set sof_pending on ce && vid_vblank in SYNCED/WAIT transition; cleared by first pushed beat, which carries tuser=1.
REQ-012 In SYNCED, each ce && vid_active_video pixel SHALL occupy lane = pixel index mod C_PACK_FACTOR.
REQ-013 Last-pixel detection SHALL use a one-pixel hold register: a beat is pushed on the ce cycle after its last pixel, tlast=1 if that cycle has vid_active_video=0.
REQ-014 Partial final beat (line length not multiple of C_PACK_FACTOR) SHALL zero-fill unused upper lanes and set tlast=1.
REQ-015 fid SHALL equal vid_field_id sampled with the beat's first pixel.
REQ-016 FIFO SHALL be first-word-fall-through, width TW+3; tvalid = not empty; pop on tvalid && tready.
REQ-017 Latency: pushed beat SHALL present on tvalid the clock after the push edge when FIFO was empty.
REQ-018 Push with FIFO full SHALL be rejected even if a pop occurs same cycle; overflow pulses 1 cycle.
REQ-019 With C_DROP_ON_OVERFLOW=1, rejection SHALL enter DROP_LINE, discarding pixels until vid_active_video sampled 0, then return to SYNCED with lane index 0; lines_dropped += 1 (saturate at 16'hFFFF).
REQ-020 With C_DROP_ON_OVERFLOW=0, only the rejected beat is lost; lines_dropped increments once per affected line.
REQ-021 vid_io_in_ce=0 SHALL freeze the input path; FIFO read side runs every clock.

Reset
REQ-022 Reset SHALL clear FIFO pointers, hold register, lane index, sof_pending, lines_dropped; tvalid, tuser, tlast, fid, overflow, synced = 0; tdata = 0.
REQ-023 Reset asserted mid-line SHALL drop all buffered beats; after release no beat is emitted before the next vblank.

Structure
REQ-024 State encoding, PW/TW width functions and FIFO entry field offsets SHALL live in a shared package vid_in_axi4s_pkg.
REQ-025 FIFO SHALL be one sub-module vid_in_axi4s_sync_fifo (single-clock, FWFT, full/empty flags).

Verification (C_PACK_FACTOR=2, 3x8-bit, depth 32)
REQ-026 vblank then 4-pixel line 24'h010203,040506,070809,0A0B0C -> beats 48'h040506010203 tuser=1, 48'h0A0B0C070809 tlast=1.
REQ-027 3-pixel line -> second beat 48'h000000_p2 with tlast=1.
REQ-028 tready=0, push 33 beats in one line -> single overflow pulse, lines_dropped=1, 32 intact beats drain on tready=1.
REQ-029 ce alternating 1/0 over REQ-026 stimulus -> identical beat sequence.
REQ-030 reset mid-line, release -> tvalid=0, synced=0 until vblank; axis_enable=0 during vblank -> no beats.
